// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, runs one outstanding
// req/gnt/rvalid transaction and hands instructions to decode.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'h4
) (
   input  logic        sclk_i,
   input  logic        srst_i,
   input  logic        fetch_en_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        kill_q, kill_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] redir_pc;

   assign redir_pc = {redirect_pc_i[31:2], 2'b00};

   // State and datapath registers, async reset to the fetch reset state
   always_ff @(posedge sclk_i or posedge srst_i) begin
      if (srst_i) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         req_pc_q     <= 32'h0;
         kill_q       <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= 32'h0;
         inst_pc_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         kill_q       <= kill_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   // Next-state and datapath updates; a redirect overrides any PC update
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      kill_d       = kill_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      unique case (state_q)
         IDLE: begin
            if (fetch_en_i) state_d = REQ;
         end
         REQ: begin
            if (imem_gnt_i) begin
               req_pc_d = pc_q;
               state_d  = WAIT;
               if (redirect_i) kill_d = 1'b1;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               if (imem_rvalid_i) begin
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  kill_d  = 1'b1;
               end
            end else if (imem_rvalid_i) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = fetch_en_i ? REQ : IDLE;
               end else begin
                  inst_d       = imem_rdata_i;
                  inst_pc_d    = req_pc_q;
                  inst_valid_d = 1'b1;
                  pc_d         = req_pc_q + PC_STEP;
                  state_d      = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_i) begin
               inst_valid_d = 1'b0;
               state_d      = REQ;
            end else if (inst_ready_i) begin
               inst_valid_d = 1'b0;
               state_d      = fetch_en_i ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect_i) pc_d = redir_pc;
   end

   assign imem_req_o   = (state_q == REQ);
   assign imem_addr_o  = pc_q;
   assign inst_valid_o = inst_valid_q;
   assign inst_o       = inst_q;
   assign inst_pc_o    = inst_pc_q;
   assign busy_o       = (state_q != IDLE);

endmodule
